// File: rtl/hazard_fwd_unit_pkg.sv
// Shared optype and forward-select encodings for the hazard unit and the decoder.
// Pure type definitions: no latency, no backpressure.
package hazard_pkg;

  typedef enum logic [1:0] {
    OPTYPE_NONE  = 2'd0,
    OPTYPE_ALU   = 2'd1,
    OPTYPE_LOAD  = 2'd2,
    OPTYPE_STORE = 2'd3
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EX_ALU   = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage hazard inputs and pipeline control outputs between the core and the hazard unit.
// Wires only: zero latency; stalls are signalled through PC_EN_IF/reg_FD_EN.
interface hazard_fwd_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
);
  optype_e           hazard_optype_ID;
  logic              rs1use_ID;
  logic              rs2use_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic [REG_AW-1:0] rd_ID;
  logic              Branch_ID;
  logic              PC_EN_IF;
  logic              reg_FD_EN;
  logic              reg_FD_flush;
  logic              reg_DE_flush;
  fwd_sel_e          forward_ctrl_A;
  fwd_sel_e          forward_ctrl_B;
  logic              forward_ctrl_ls;

  modport master (
    output hazard_optype_ID, rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, Branch_ID,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

  modport slave (
    input  hazard_optype_ID, rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, Branch_ID,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward select from EX/MEM producers; youngest producer wins.
// Combinational, zero latency; an EX load match yields regfile since the stall covers it.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              use_rs,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_ex,
  input  optype_e           optype_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  optype_e           optype_mem,
  output fwd_sel_e          sel
);
  logic hit_ex;
  logic hit_mem;

  always_comb begin
    hit_ex  = use_rs && (rs != '0) && (rs == rd_ex);
    hit_mem = use_rs && (rs != '0) && (rs == rd_mem);
    sel     = FWD_RF;
    // An EX load shadows any older MEM producer of the same register.
    if (hit_ex && optype_ex == OPTYPE_ALU)          sel = FWD_EX_ALU;
    else if (hit_ex && optype_ex == OPTYPE_LOAD)    sel = FWD_RF;
    else if (hit_mem && optype_mem == OPTYPE_ALU)   sel = FWD_MEM_ALU;
    else if (hit_mem && optype_mem == OPTYPE_LOAD)  sel = FWD_MEM_LOAD;
  end
endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall, branch flush and operand forwarding for the 5-stage core.
// Outputs are combinational (0 cycles); a load-use holds PC and IF/ID for exactly one cycle.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  hazard_fwd_unit_if.slave  hz
);
  optype_e           optype_ex;
  optype_e           optype_mem;
  logic [REG_AW-1:0] rd_ex;
  logic [REG_AW-1:0] rd_mem;
  logic [REG_AW-1:0] rs2_ex;
  logic              match1_ex;
  logic              match2_ex;
  logic              load_use;
  fwd_sel_e          sel_a;
  fwd_sel_e          sel_b;

  // WB is not shadowed: operand writes there are covered by regfile write-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      optype_ex  <= OPTYPE_NONE;
      optype_mem <= OPTYPE_NONE;
      rd_ex      <= '0;
      rd_mem     <= '0;
      rs2_ex     <= '0;
    end else begin
      optype_ex  <= load_use ? OPTYPE_NONE : hz.hazard_optype_ID;
      rd_ex      <= hz.rd_ID;
      rs2_ex     <= hz.rs2_ID;
      optype_mem <= optype_ex;
      rd_mem     <= rd_ex;
    end
  end

  always_comb begin
    match1_ex = hz.rs1use_ID && (hz.rs1_ID != '0) && (hz.rs1_ID == rd_ex);
    match2_ex = hz.rs2use_ID && (hz.rs2_ID != '0) && (hz.rs2_ID == rd_ex);
    // Store data alone on an EX load does not stall; it is picked up in EX next cycle.
    load_use  = !rst && (optype_ex == OPTYPE_LOAD) &&
                (match1_ex || (match2_ex && hz.hazard_optype_ID != OPTYPE_STORE));
  end

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
    .use_rs     (hz.rs1use_ID),
    .rs         (hz.rs1_ID),
    .rd_ex      (rd_ex),
    .optype_ex  (optype_ex),
    .rd_mem     (rd_mem),
    .optype_mem (optype_mem),
    .sel        (sel_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
    .use_rs     (hz.rs2use_ID),
    .rs         (hz.rs2_ID),
    .rd_ex      (rd_ex),
    .optype_ex  (optype_ex),
    .rd_mem     (rd_mem),
    .optype_mem (optype_mem),
    .sel        (sel_b)
  );

  always_comb begin
    hz.PC_EN_IF        = !load_use;
    hz.reg_FD_EN       = !load_use;
    hz.reg_DE_flush    = load_use;
    hz.reg_FD_flush    = !rst && hz.Branch_ID && !load_use;
    hz.forward_ctrl_A  = rst ? FWD_RF : sel_a;
    hz.forward_ctrl_B  = rst ? FWD_RF : sel_b;
    hz.forward_ctrl_ls = !rst && (optype_ex == OPTYPE_STORE) && (optype_mem == OPTYPE_LOAD) &&
                         (rs2_ex != '0) && (rs2_ex == rd_mem);
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding, load-use stall, store exception, branch, reset.
// Inputs change just after a rising edge; outputs are checked 1 time unit later.
module tb_hazard_fwd_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_AW(5)) hz ();

  hazard_fwd_unit #(.REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input optype_e op, input logic u1, input logic u2,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic br);
    hz.hazard_optype_ID = op;
    hz.rs1use_ID        = u1;
    hz.rs2use_ID        = u2;
    hz.rs1_ID           = rs1;
    hz.rs2_ID           = rs2;
    hz.rd_ID            = rd;
    hz.Branch_ID        = br;
    #1;
  endtask

  task automatic cmp1(input string tag, input string field,
                      input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic pc, input logic fd_en,
                     input logic fd_fl, input logic de_fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic ls);
    cmp1(tag, "PC_EN_IF",        {1'b0, hz.PC_EN_IF},        {1'b0, pc});
    cmp1(tag, "reg_FD_EN",       {1'b0, hz.reg_FD_EN},       {1'b0, fd_en});
    cmp1(tag, "reg_FD_flush",    {1'b0, hz.reg_FD_flush},    {1'b0, fd_fl});
    cmp1(tag, "reg_DE_flush",    {1'b0, hz.reg_DE_flush},    {1'b0, de_fl});
    cmp1(tag, "forward_ctrl_A",  hz.forward_ctrl_A,          fa);
    cmp1(tag, "forward_ctrl_B",  hz.forward_ctrl_B,          fb);
    cmp1(tag, "forward_ctrl_ls", {1'b0, hz.forward_ctrl_ls}, {1'b0, ls});
  endtask

  initial begin
    // Reset with inputs that would otherwise flush: outputs must stay at reset values.
    set_id(OPTYPE_LOAD, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
    chk("rst_hold", 1, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    set_id(OPTYPE_NONE, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("rst_after", 1, 1, 0, 0, 0, 0, 0);
    tick();

    // 1: ALU x5 forwarded from EX, then from MEM
    set_id(OPTYPE_ALU, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0);
    chk("t1_idle", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_ALU, 1'b1, 1'b0, 5'd5, 5'd0, 5'd10, 1'b0);
    chk("t1_ex_alu", 1, 1, 0, 0, 1, 0, 0);
    tick();
    set_id(OPTYPE_NONE, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    chk("t1_mem_alu", 1, 1, 0, 0, 2, 0, 0);
    tick();

    // 2: lw x6 then add reading rs2=x6 -> one-cycle stall, then MEM load forward
    set_id(OPTYPE_LOAD, 1'b1, 1'b0, 5'd0, 5'd0, 5'd6, 1'b0);
    chk("t2_lw_x0src", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_ALU, 1'b0, 1'b1, 5'd0, 5'd6, 5'd12, 1'b0);
    chk("t2_stall", 0, 0, 0, 1, 0, 0, 0);
    tick();
    chk("t2_mem_load", 1, 1, 0, 0, 0, 3, 0);
    tick();

    // 3: lw x7 then sw with rs2=x7 -> no stall, store data forwarded in EX
    set_id(OPTYPE_LOAD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    chk("t3_lw", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_STORE, 1'b1, 1'b1, 5'd2, 5'd7, 5'd0, 1'b0);
    chk("t3_sw_nostall", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_NONE, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("t3_ls", 1, 1, 0, 0, 0, 0, 1);
    tick();

    // 4: lw x8 then beq x8,x0 taken -> stall beats flush, then flush with load forward
    set_id(OPTYPE_LOAD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b0);
    chk("t4_lw", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_NONE, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b1);
    chk("t4_br_stall", 0, 0, 0, 1, 0, 0, 0);
    tick();
    chk("t4_br_flush", 1, 1, 1, 0, 3, 0, 0);
    tick();

    // 5: x0 never forwards; EX beats MEM on the same register
    set_id(OPTYPE_ALU, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("t5_alu_x0", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_ALU, 1'b1, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0);
    chk("t5_read_x0", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_ALU, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0);
    chk("t5_alu_x9b", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_NONE, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    chk("t5_ex_wins", 1, 1, 0, 0, 1, 1, 0);
    tick();

    // 6: reset during a load-use stall
    set_id(OPTYPE_LOAD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 1'b0);
    chk("t6_lw", 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(OPTYPE_ALU, 1'b1, 1'b0, 5'd6, 5'd0, 5'd13, 1'b1);
    chk("t6_stall", 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_forced", 1, 1, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    set_id(OPTYPE_ALU, 1'b1, 1'b0, 5'd6, 5'd0, 5'd13, 1'b0);
    chk("t6_after_rst", 1, 1, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
